// File: rtl/comparador_multicanal_pkg.sv
// Shared definitions for the multi-channel magnitude comparator.
//   state_t  : controller states (IDLE -> SCAN -> DONE -> IDLE)
//   MODE_*   : values of the mode input (maximum / minimum search)
package comparador_multicanal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/comparador_multicanal_celda.sv
// Combinational comparison cell: decides whether operand a strictly beats
// operand b under the selected search mode, and whether they are equal.
// Ports:
//   a, b    in  WIDTH  operands (two's complement when SIGNED=1)
//   mode    in  1      MODE_MAX: a > b wins; MODE_MIN: a < b wins
//   better  out 1      a strictly beats b
//   equal   out 1      a == b
module comparador_celda
    import comparador_multicanal_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             better,
    output logic             equal
);

    logic gt;
    logic lt;

    always_comb begin
        if (SIGNED != 0) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        equal  = (a == b);
        better = (mode == MODE_MIN) ? lt : gt;
    end

endmodule

// File: rtl/comparador_multicanal.sv
// Sequential N-channel magnitude comparator. On start, snapshots all channels
// and the mode, then scans one channel per clock to find the maximum (or
// minimum), its lowest channel index, and tie / all-equal flags.
// Ports:
//   clk      in   1           rising-edge clock
//   rst      in   1           synchronous reset, active-high
//   start    in   1           launch request, honoured only in IDLE
//   mode     in   1           0 = maximum, 1 = minimum (captured with start)
//   data_in  in   N_CH*WIDTH  channel k at data_in[k*WIDTH +: WIDTH]
//   busy     out  1           high while scanning and in the DONE cycle
//   done     out  1           one-cycle pulse, result fields valid from here on
//   result   out  WIDTH       winning value (0 when all equal and ZERO_ON_TIE)
//   index    out  IDX_W       channel index of the winner
//   tie      out  1           winning value present in two or more channels
//   all_eq   out  1           all channels hold the same value
module comparador_multicanal
    import comparador_multicanal_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int N_CH        = 4,
    parameter int SIGNED      = 0,
    parameter int ZERO_ON_TIE = 1,
    localparam int IDX_W      = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [N_CH*WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [IDX_W-1:0]      index,
    output logic                  tie,
    output logic                  all_eq
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   snap [N_CH];
    logic               snap_load;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   best_q, best_d;
    logic [IDX_W-1:0]   bidx_q, bidx_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic               tie_q, tie_d;
    logic               eq_q, eq_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               tie_o_q, tie_o_d;
    logic               all_eq_q, all_eq_d;

    logic [WIDTH-1:0]   cand;
    logic               cand_better;
    logic               cand_equal;

    assign cand = snap[i_q];

    comparador_celda #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_celda (
        .a      (cand),
        .b      (best_q),
        .mode   (mode_q),
        .better (cand_better),
        .equal  (cand_equal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            best_q   <= '0;
            bidx_q   <= '0;
            i_q      <= '0;
            tie_q    <= 1'b0;
            eq_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            index_q  <= '0;
            tie_o_q  <= 1'b0;
            all_eq_q <= 1'b0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            best_q   <= best_d;
            bidx_q   <= bidx_d;
            i_q      <= i_d;
            tie_q    <= tie_d;
            eq_q     <= eq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            index_q  <= index_d;
            tie_o_q  <= tie_o_d;
            all_eq_q <= all_eq_d;
            if (snap_load) begin
                for (int unsigned k = 0; k < N_CH; k++) begin
                    snap[k] <= data_in[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_load = 1'b0;
        mode_d    = mode_q;
        best_d    = best_q;
        bidx_d    = bidx_q;
        i_d       = i_q;
        tie_d     = tie_q;
        eq_d      = eq_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        index_d   = index_q;
        tie_o_d   = tie_o_q;
        all_eq_d  = all_eq_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    snap_load = 1'b1;
                    mode_d    = mode;
                    best_d    = data_in[WIDTH-1:0];
                    bidx_d    = '0;
                    i_d       = IDX_W'(1);
                    tie_d     = 1'b0;
                    eq_d      = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            ST_SCAN: begin
                if (cand_better) begin
                    best_d = cand;
                    bidx_d = i_q;
                    tie_d  = 1'b0;
                end else if (cand_equal) begin
                    tie_d  = 1'b1;
                end
                if (!cand_equal) begin
                    eq_d = 1'b0;
                end
                i_d = i_q + IDX_W'(1);
                // Output registers load from the last compare's next-state
                // values so done and the result appear together in DONE.
                if (i_q == LAST_IDX) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    tie_o_d  = tie_d;
                    all_eq_d = eq_d;
                    if ((ZERO_ON_TIE != 0) && eq_d) begin
                        result_d = '0;
                        index_d  = '0;
                    end else begin
                        result_d = best_d;
                        index_d  = bidx_d;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign index  = index_q;
    assign tie    = tie_o_q;
    assign all_eq = all_eq_q;

endmodule

// File: tb/tb_comparador_multicanal.sv
// Scoreboard bench: three instances (default, ZERO_ON_TIE=0, SIGNED=1).
// The driver pushes the expected response for each launch; a monitor on the
// falling edge pops and compares whenever an instance pulses done.
module tb_comparador_multicanal;

    localparam int WIDTH = 3;
    localparam int N_CH  = 4;
    localparam int IDX_W = 2;

    typedef struct {
        int               dut;
        int               cyc;
        logic [WIDTH-1:0] res;
        logic [IDX_W-1:0] idx;
        logic             tie;
        logic             alleq;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start_v [3];
    logic                  mode = 1'b0;
    logic [N_CH*WIDTH-1:0] data_in = '0;

    logic                  busy_v   [3];
    logic                  done_v   [3];
    logic [WIDTH-1:0]      res_v    [3];
    logic [IDX_W-1:0]      idx_v    [3];
    logic                  tie_v    [3];
    logic                  alleq_v  [3];

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comparador_multicanal #(
        .WIDTH(WIDTH), .N_CH(N_CH), .SIGNED(0), .ZERO_ON_TIE(1)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .data_in(data_in),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .index(idx_v[0]),
        .tie(tie_v[0]), .all_eq(alleq_v[0])
    );

    comparador_multicanal #(
        .WIDTH(WIDTH), .N_CH(N_CH), .SIGNED(0), .ZERO_ON_TIE(0)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .data_in(data_in),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .index(idx_v[1]),
        .tie(tie_v[1]), .all_eq(alleq_v[1])
    );

    comparador_multicanal #(
        .WIDTH(WIDTH), .N_CH(N_CH), .SIGNED(1), .ZERO_ON_TIE(1)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .data_in(data_in),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .index(idx_v[2]),
        .tie(tie_v[2]), .all_eq(alleq_v[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N_CH*WIDTH-1:0] pack(input logic [WIDTH-1:0] c0,
                                                   input logic [WIDTH-1:0] c1,
                                                   input logic [WIDTH-1:0] c2,
                                                   input logic [WIDTH-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input int at, input int r, input int ix,
                            input int t, input int ae);
        exp_t e;
        e.dut   = d;
        e.cyc   = at;
        e.res   = WIDTH'(r);
        e.idx   = IDX_W'(ix);
        e.tie   = t[0];
        e.alleq = ae[0];
        q.push_back(e);
    endtask

    // Launch one operation on instance d with a one-cycle start pulse.
    task automatic issue(input int d, input logic [N_CH*WIDTH-1:0] din, input logic m,
                         input int r, input int ix, input int t, input int ae);
        data_in = din;
        mode    = m;
        push_exp(d, cyc + N_CH, r, ix, t, ae);
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        tick();
        tick();
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_busy"},   int'(busy_v[d]),  0);
        chk({tag, "_done"},   int'(done_v[d]),  0);
        chk({tag, "_result"}, int'(res_v[d]),   0);
        chk({tag, "_index"},  int'(idx_v[d]),   0);
        chk({tag, "_tie"},    int'(tie_v[d]),   0);
        chk({tag, "_all_eq"}, int'(alleq_v[d]), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (done_v[d] === 1'b1) begin
                if (q.size() == 0 || q[0].dut != d) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d at cycle %0d: got done=1, expected 0",
                             d, cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_latency", cyc, e.cyc);
                    chk("busy_at_done", int'(busy_v[d]), 1);
                    chk("result", int'(res_v[d]), int'(e.res));
                    chk("index", int'(idx_v[d]), int'(e.idx));
                    chk("tie", int'(tie_v[d]), int'(e.tie));
                    chk("all_eq", int'(alleq_v[d]), int'(e.alleq));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) chk_zero(d, "reset");

        // Basic max / min
        issue(0, pack(5, 2, 7, 1), 1'b0, 7, 2, 0, 0);
        drain();
        issue(0, pack(5, 2, 7, 1), 1'b1, 1, 3, 0, 0);
        drain();

        // Tie at the maximum; previous result must hold while scanning
        issue(0, pack(6, 3, 6, 2), 1'b0, 6, 0, 1, 0);
        chk("hold_result_in_scan", int'(res_v[0]), 1);
        chk("hold_index_in_scan", int'(idx_v[0]), 3);
        chk("busy_in_scan", int'(busy_v[0]), 1);
        drain();

        // Tie at the minimum, lowest index wins
        issue(0, pack(3, 1, 5, 1), 1'b1, 1, 1, 1, 0);
        drain();

        // All equal: zeroed result vs. plain result
        issue(0, pack(4, 4, 4, 4), 1'b0, 0, 0, 1, 1);
        drain();
        issue(1, pack(4, 4, 4, 4), 1'b0, 4, 0, 1, 1);
        drain();

        // Signed operands {-1, 3, -4, 0}
        issue(2, pack(3'b111, 3'b011, 3'b100, 3'b000), 1'b0, 3, 1, 0, 0);
        drain();
        issue(2, pack(3'b111, 3'b011, 3'b100, 3'b000), 1'b1, 4, 2, 0, 0);
        drain();

        // Inputs changed and start pulsed mid-scan: no effect, no extra done
        issue(0, pack(5, 2, 7, 1), 1'b0, 7, 2, 0, 0);
        tick();
        data_in = pack(0, 0, 0, 0);
        mode    = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        drain();

        // Start held high re-launches on the first IDLE cycle
        data_in = pack(2, 6, 6, 1);
        mode    = 1'b1;
        push_exp(0, cyc + N_CH, 1, 3, 0, 0);
        push_exp(0, cyc + 2*N_CH + 1, 1, 3, 0, 0);
        start_v[0] = 1'b1;
        repeat (6) tick();
        start_v[0] = 1'b0;
        drain();

        // Reset mid-scan aborts without a done pulse
        data_in = pack(1, 7, 2, 3);
        mode    = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero(0, "abort");
        repeat (8) tick();

        // Recovery after abort
        issue(0, pack(0, 7, 3, 7), 1'b0, 7, 1, 1, 0);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
